palette_lookup_arbiter: RTL and testbench

- Shares the single combinational 512-entry, 12-bit RGB palette ROM between NUM_REQ pixel sources: background, player sprite, ball sprites and harpoon/text overlay.
- Each source issues an index plus a tag (pixel x/y cookie) with valid/ready and receives the 4:4:4 colour back, tagged with its requester ID.
- Sits between the sprite fetch units and the frame/line buffer writer; the ROM instance lives outside this block.

---
 rtl/palette_pkg.sv | 27 ++
 rtl/palette_lookup_arbiter_rr_arbiter.sv | 47 ++++
 rtl/palette_lookup_arbiter.sv | 105 ++++++++++
 tb/tb_palette_lookup_arbiter.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/palette_pkg.sv
// Shared palette definitions: ROM geometry and the 4:4:4 colour record
// exchanged between the palette ROM, this arbiter and the line buffer writer.
package palette_pkg;

    localparam int PAL_IDX_W = 9;
    localparam int PAL_CH_W  = 4;
    localparam int PAL_DEPTH = 512;

    typedef logic [PAL_IDX_W-1:0] pal_idx_t;

    typedef struct packed {
        logic [PAL_CH_W-1:0] red;
        logic [PAL_CH_W-1:0] green;
        logic [PAL_CH_W-1:0] blue;
    } rgb444_t;

    function automatic rgb444_t make_rgb(input logic [PAL_CH_W-1:0] r,
                                         input logic [PAL_CH_W-1:0] g,
                                         input logic [PAL_CH_W-1:0] b);
        rgb444_t c;
        c.red   = r;
        c.green = g;
        c.blue  = b;
        return c;
    endfunction

endpackage

// File: rtl/palette_lookup_arbiter_rr_arbiter.sv
// Round-robin arbiter with a last-grant pointer; the search starts one past
// the most recently accepted requester so every active source is served in turn.
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [NUM_REQ-1:0]         req,
    input  logic                       advance,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] grant_id
);

    localparam int ID_W = $clog2(NUM_REQ);

    logic [ID_W-1:0] last;
    logic            found;
    int              cand;

    always_comb begin
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        cand     = 0;
        if (advance) begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                cand = int'(last) + k;
                if (cand >= NUM_REQ) cand = cand - NUM_REQ;
                if (!found && req[cand]) begin
                    grant[cand] = 1'b1;
                    grant_id    = ID_W'(cand);
                    found       = 1'b1;
                end
            end
        end
    end

    // A grant is only ever offered when the transfer is accepted, so any grant moves LAST.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last <= ID_W'(NUM_REQ - 1);
        end else if (found) begin
            last <= grant_id;
        end
    end

endmodule

// File: rtl/palette_lookup_arbiter.sv
// Shares one combinational palette ROM between NUM_REQ pixel sources through a
// two-stage pipeline: stage A addresses the ROM, stage B holds the tagged colour.
module palette_lookup_arbiter
    import palette_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = PAL_IDX_W,
    parameter int TAG_W   = 10
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*IDX_W-1:0]   req_index,
    input  logic [NUM_REQ*TAG_W-1:0]   req_tag,
    output logic [IDX_W-1:0]           pal_index,
    input  logic [PAL_CH_W-1:0]        pal_red,
    input  logic [PAL_CH_W-1:0]        pal_green,
    input  logic [PAL_CH_W-1:0]        pal_blue,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0] rsp_id,
    output logic [TAG_W-1:0]           rsp_tag,
    output logic [PAL_CH_W-1:0]        rsp_red,
    output logic [PAL_CH_W-1:0]        rsp_green,
    output logic [PAL_CH_W-1:0]        rsp_blue
);

    localparam int ID_W = $clog2(NUM_REQ);

    logic               vld_p1;
    logic [IDX_W-1:0]   idx_p1;
    logic [TAG_W-1:0]   tag_p1;
    logic [ID_W-1:0]    id_p1;

    logic               vld_p2;
    logic [TAG_W-1:0]   tag_p2;
    logic [ID_W-1:0]    id_p2;
    rgb444_t            rgb_p2;

    logic               b_load;
    logic               a_can_load;
    logic               accept;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_id;

    assign b_load = vld_p1 && (!vld_p2 || rsp_ready);
    // Holding off while reset is asserted keeps req_ready low during reset.
    assign a_can_load = (!vld_p1 || b_load) && reset_n;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .clk      (clk),
        .reset_n  (reset_n),
        .req      (req_valid),
        .advance  (a_can_load),
        .grant    (grant),
        .grant_id (grant_id)
    );

    assign req_ready = grant;
    assign accept    = |grant;

    // Stage A: granted request, drives the ROM address
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_p1 <= 1'b0;
            idx_p1 <= '0;
            tag_p1 <= '0;
            id_p1  <= '0;
        end else if (a_can_load) begin
            vld_p1 <= accept;
            if (accept) begin
                idx_p1 <= req_index[int'(grant_id)*IDX_W +: IDX_W];
                tag_p1 <= req_tag[int'(grant_id)*TAG_W +: TAG_W];
                id_p1  <= grant_id;
            end
        end
    end

    // Stage B: captured colour, drives the response
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_p2 <= 1'b0;
            tag_p2 <= '0;
            id_p2  <= '0;
            rgb_p2 <= '0;
        end else if (b_load) begin
            vld_p2 <= 1'b1;
            tag_p2 <= tag_p1;
            id_p2  <= id_p1;
            rgb_p2 <= make_rgb(pal_red, pal_green, pal_blue);
        end else if (rsp_ready) begin
            vld_p2 <= 1'b0;
        end
    end

    assign pal_index = idx_p1;
    assign rsp_valid = vld_p2;
    assign rsp_id    = id_p2;
    assign rsp_tag   = tag_p2;
    assign rsp_red   = rgb_p2.red;
    assign rsp_green = rgb_p2.green;
    assign rsp_blue  = rgb_p2.blue;

endmodule

// File: tb/tb_palette_lookup_arbiter.sv
// Bench for palette_lookup_arbiter: directed scenarios plus random traffic
// compared against an in-order two-entry buffer model with round-robin choice.
module tb_palette_lookup_arbiter;

    localparam int N  = 4;
    localparam int IW = 9;
    localparam int TW = 10;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [N-1:0]  req_valid = '0;
    logic [N-1:0]  req_ready;
    logic [N*IW-1:0] req_index = '0;
    logic [N*TW-1:0] req_tag = '0;
    logic [IW-1:0] pal_index;
    logic [3:0]    pal_red, pal_green, pal_blue;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [1:0]    rsp_id;
    logic [TW-1:0] rsp_tag;
    logic [3:0]    rsp_red, rsp_green, rsp_blue;
    logic [11:0]   rsp_rgb;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int            id;
        logic [TW-1:0] tag;
        logic [11:0]   rgb;
        int            acc;
    } item_t;

    item_t q[$];
    int    last_m = N - 1;
    int    cyc = 0;

    always #5 clk = ~clk;

    function automatic logic [11:0] rom(input logic [IW-1:0] i);
        case (i)
            9'd0:    return 12'hBCD;
            9'd3:    return 12'hFFF;
            9'd9:    return 12'hC80;
            default: return {i[3:0] ^ i[7:4], i[8:5], ~i[3:0]};
        endcase
    endfunction

    assign {pal_red, pal_green, pal_blue} = rom(pal_index);
    assign rsp_rgb = {rsp_red, rsp_green, rsp_blue};

    palette_lookup_arbiter #(.NUM_REQ(N), .IDX_W(IW), .TAG_W(TW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_index (req_index),
        .req_tag   (req_tag),
        .pal_index (pal_index),
        .pal_red   (pal_red),
        .pal_green (pal_green),
        .pal_blue  (pal_blue),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_tag   (rsp_tag),
        .rsp_red   (rsp_red),
        .rsp_green (rsp_green),
        .rsp_blue  (rsp_blue)
    );

    // The pipeline behaves as a two-entry in-order buffer: it accepts unless
    // full, or when full and the head response is leaving this cycle.
    function automatic logic [N-1:0] exp_grant();
        int j;
        if (!(q.size() < 2 || rsp_ready)) return '0;
        for (int k = 1; k <= N; k++) begin
            j = (last_m + k) % N;
            if (req_valid[j]) return N'(1 << j);
        end
        return '0;
    endfunction

    function automatic logic exp_rsp_valid();
        return (q.size() > 0) && (cyc - q[0].acc >= 2);
    endfunction

    task automatic tick();
        logic [N-1:0] g;
        item_t it;
        int j;
        g = exp_grant();
        if (exp_rsp_valid() && rsp_ready) void'(q.pop_front());
        if (g != '0) begin
            j = 0;
            for (int i = 0; i < N; i++) if (g[i]) j = i;
            it.id  = j;
            it.tag = req_tag[j*TW +: TW];
            it.rgb = rom(req_index[j*IW +: IW]);
            it.acc = cyc;
            q.push_back(it);
            last_m = j;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        req_valid = '0;
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        q.delete();
        last_m = N - 1;
    endtask

    task automatic set_slot(input int i, input logic [IW-1:0] idx, input logic [TW-1:0] tag);
        req_index[i*IW +: IW] = idx;
        req_tag[i*TW +: TW]   = tag;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        req_valid = 4'hF;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (req_ready !== 4'h0) begin errors++; $display("FAIL reset_ready got %b want 0000", req_ready); end
        checks++;
        if ({rsp_valid, rsp_id, rsp_tag, rsp_rgb} !== 25'h0) begin
            errors++;
            $display("FAIL reset_rsp got v=%b id=%0d tag=%h rgb=%h want all zero", rsp_valid, rsp_id, rsp_tag, rsp_rgb);
        end
        checks++;
        if (pal_index !== 9'd0) begin errors++; $display("FAIL reset_pal_index got %0d want 0", pal_index); end
        req_valid = '0;
        reset_n = 1'b1;
        q.delete();
        last_m = N - 1;
        cyc = 0;
    endtask

    task automatic test_single();
        set_slot(2, 9'd3, 10'h155);
        req_valid = 4'b0100;
        rsp_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_grant got %b want 0100", req_ready); end
        tick();
        req_valid = '0;
        #1;
        checks++;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_early got %b want 0", rsp_valid); end
        tick();
        checks++;
        if ({rsp_valid, rsp_id, rsp_tag, rsp_rgb} !== {1'b1, 2'd2, 10'h155, 12'hFFF}) begin
            errors++;
            $display("FAIL single_rsp got v=%b id=%0d tag=%h rgb=%h want 1/2/155/fff", rsp_valid, rsp_id, rsp_tag, rsp_rgb);
        end
        tick();
        checks++;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_hold got %b want 0", rsp_valid); end
    endtask

    task automatic test_round_robin();
        logic [11:0] want;
        do_reset();
        for (int i = 0; i < N; i++) set_slot(i, (i % 2 == 0) ? 9'd0 : 9'd9, TW'(10'h100 + i));
        req_valid = 4'hF;
        rsp_ready = 1'b1;
        #1;
        for (int k = 0; k < 12; k++) begin
            checks++;
            if (req_ready !== 4'(1 << (k % 4))) begin
                errors++; $display("FAIL rr_grant k=%0d got %b want %b", k, req_ready, 4'(1 << (k % 4)));
            end
            if (k >= 2) begin
                want = ((k - 2) % 2 == 0) ? 12'hBCD : 12'hC80;
                checks++;
                if ({rsp_valid, rsp_id, rsp_rgb} !== {1'b1, 2'((k - 2) % 4), want}) begin
                    errors++;
                    $display("FAIL rr_rsp k=%0d got v=%b id=%0d rgb=%h want 1/%0d/%h", k, rsp_valid, rsp_id, rsp_rgb, (k - 2) % 4, want);
                end
            end
            tick();
        end
        req_valid = '0;
        repeat (3) tick();
    endtask

    task automatic test_backpressure();
        do_reset();
        set_slot(0, 9'd3, 10'h011);
        set_slot(1, 9'd9, 10'h022);
        rsp_ready = 1'b1;
        req_valid = 4'b0001;
        #1;
        tick();
        req_valid = 4'b0010;
        #1;
        tick();
        req_valid = 4'hF;
        rsp_ready = 1'b0;
        #1;
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (req_ready !== 4'h0) begin errors++; $display("FAIL bp_ready k=%0d got %b want 0000", k, req_ready); end
            checks++;
            if ({rsp_valid, rsp_id, rsp_tag, rsp_rgb} !== {1'b1, 2'd0, 10'h011, 12'hFFF}) begin
                errors++;
                $display("FAIL bp_hold k=%0d got v=%b id=%0d tag=%h rgb=%h want 1/0/011/fff", k, rsp_valid, rsp_id, rsp_tag, rsp_rgb);
            end
            checks++;
            if (pal_index !== 9'd9) begin errors++; $display("FAIL bp_pal k=%0d got %0d want 9", k, pal_index); end
            tick();
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        #1;
        checks++;
        if ({rsp_valid, rsp_id, rsp_tag} !== {1'b1, 2'd0, 10'h011}) begin
            errors++; $display("FAIL bp_first got v=%b id=%0d tag=%h want 1/0/011", rsp_valid, rsp_id, rsp_tag);
        end
        tick();
        checks++;
        if ({rsp_valid, rsp_id, rsp_tag, rsp_rgb} !== {1'b1, 2'd1, 10'h022, 12'hC80}) begin
            errors++;
            $display("FAIL bp_second got v=%b id=%0d tag=%h rgb=%h want 1/1/022/c80", rsp_valid, rsp_id, rsp_tag, rsp_rgb);
        end
        tick();
        checks++;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_dup got %b want 0", rsp_valid); end
    endtask

    task automatic test_fairness();
        int  waited;
        logic got;
        do_reset();
        set_slot(0, 9'd5, 10'h001);
        set_slot(3, 9'd7, 10'h002);
        rsp_ready = 1'b1;
        req_valid = 4'b0001;
        #1;
        tick();
        tick();
        req_valid = 4'b1001;
        waited = 0;
        got = 1'b0;
        while (!got && waited < 8) begin
            #1;
            if (req_ready[3]) got = 1'b1;
            tick();
            waited++;
            if (got) req_valid = 4'b0001;
        end
        checks++;
        if (!got || waited > N) begin
            errors++; $display("FAIL fair_bound got granted=%b after %0d cycles want within %0d", got, waited, N);
        end
        req_valid = '0;
        repeat (3) tick();
    endtask

    task automatic test_reset_stall();
        do_reset();
        set_slot(0, 9'd0, 10'h0AA);
        set_slot(2, 9'd9, 10'h0BB);
        rsp_ready = 1'b0;
        req_valid = 4'b0001;
        #1;
        tick();
        req_valid = 4'b0100;
        #1;
        tick();
        req_valid = 4'hF;
        #1;
        checks++;
        if (rsp_valid !== 1'b1) begin errors++; $display("FAIL rst_full got %b want 1", rsp_valid); end
        #1;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({rsp_valid, rsp_id, rsp_tag, rsp_rgb, pal_index, req_ready} !== 38'h0) begin
            errors++;
            $display("FAIL rst_async got v=%b id=%0d tag=%h rgb=%h pal=%0d rdy=%b want all zero",
                     rsp_valid, rsp_id, rsp_tag, rsp_rgb, pal_index, req_ready);
        end
        @(posedge clk);
        #1;
        req_valid = '0;
        reset_n = 1'b1;
        q.delete();
        last_m = N - 1;
        set_slot(1, 9'd9, 10'h3AA);
        req_valid = 4'b0010;
        rsp_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin errors++; $display("FAIL rst_regrant got %b want 0010", req_ready); end
        tick();
        req_valid = '0;
        #1;
        checks++;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_stale got %b want 0", rsp_valid); end
        tick();
        checks++;
        if ({rsp_valid, rsp_id, rsp_tag, rsp_rgb} !== {1'b1, 2'd1, 10'h3AA, 12'hC80}) begin
            errors++;
            $display("FAIL rst_rsp got v=%b id=%0d tag=%h rgb=%h want 1/1/3aa/c80", rsp_valid, rsp_id, rsp_tag, rsp_rgb);
        end
        tick();
        checks++;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_after got %b want 0", rsp_valid); end
    endtask

    task automatic test_sparse();
        do_reset();
        set_slot(0, 9'd3, 10'h001);
        set_slot(1, 9'd0, 10'h002);
        set_slot(3, 9'd9, 10'h003);
        rsp_ready = 1'b0;
        req_valid = 4'b0001;
        #1;
        tick();
        req_valid = 4'b0010;
        #1;
        tick();
        req_valid = 4'b1000;
        #1;
        checks++;
        if (req_ready !== 4'h0) begin errors++; $display("FAIL sparse_stall got %b want 0000", req_ready); end
        tick();
        req_valid = '0;
        tick();
        rsp_ready = 1'b1;
        #1;
        checks++;
        if ({rsp_valid, rsp_id, rsp_tag, rsp_rgb} !== {1'b1, 2'd0, 10'h001, 12'hFFF}) begin
            errors++;
            $display("FAIL sparse_rsp0 got v=%b id=%0d tag=%h rgb=%h want 1/0/001/fff", rsp_valid, rsp_id, rsp_tag, rsp_rgb);
        end
        tick();
        checks++;
        if ({rsp_valid, rsp_id, rsp_tag, rsp_rgb} !== {1'b1, 2'd1, 10'h002, 12'hBCD}) begin
            errors++;
            $display("FAIL sparse_rsp1 got v=%b id=%0d tag=%h rgb=%h want 1/1/002/bcd", rsp_valid, rsp_id, rsp_tag, rsp_rgb);
        end
        tick();
        checks++;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL sparse_extra got %b want 0", rsp_valid); end
        tick();
        checks++;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL sparse_extra2 got %b want 0", rsp_valid); end
        req_valid = 4'b1001;
        #1;
        checks++;
        if (req_ready !== 4'b1000) begin errors++; $display("FAIL sparse_last got %b want 1000", req_ready); end
        tick();
        req_valid = '0;
        repeat (3) tick();
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            req_valid = N'($urandom);
            for (int i = 0; i < N; i++) set_slot(i, IW'($urandom_range(0, 511)), TW'($urandom));
            rsp_ready = ($urandom_range(0, 3) != 0);
            #1;
            checks++;
            if (req_ready !== exp_grant()) begin
                errors++; $display("FAIL rand_grant c=%0d got %b want %b", c, req_ready, exp_grant());
            end
            checks++;
            if (rsp_valid !== exp_rsp_valid()) begin
                errors++; $display("FAIL rand_valid c=%0d got %b want %b", c, rsp_valid, exp_rsp_valid());
            end
            if (exp_rsp_valid()) begin
                checks++;
                if ({rsp_id, rsp_tag, rsp_rgb} !== {2'(q[0].id), q[0].tag, q[0].rgb}) begin
                    errors++;
                    $display("FAIL rand_rsp c=%0d got id=%0d tag=%h rgb=%h want %0d/%h/%h",
                             c, rsp_id, rsp_tag, rsp_rgb, q[0].id, q[0].tag, q[0].rgb);
                end
            end
            tick();
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (4) tick();
        checks++;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rand_drain got %b want 0", rsp_valid); end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_fairness();
        test_reset_stall();
        test_sparse();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
